// File: rtl/alu_mc_pkg.sv
// Shared ALU header: op codes, FSM state encoding and small decode helpers.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OpPass  = 4'b0000,
    OpXor   = 4'b0001,
    OpSlbi  = 4'b0010,
    OpAndn  = 4'b0011,
    OpAdd   = 4'b0100,
    OpSub   = 4'b0101,
    OpBtr   = 4'b0110,
    OpSrl   = 4'b0111,
    OpSll   = 4'b1000,
    OpRor   = 4'b1001,
    OpRol   = 4'b1010,
    OpMul   = 4'b1011,
    OpMulhu = 4'b1100
  } alu_op_e;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StMulIter = 2'd1,
    StDone    = 2'd2
  } alu_state_e;

  function automatic logic is_mul_op(input logic [3:0] op);
    return (op == OpMul) || (op == OpMulhu);
  endfunction

  function automatic logic is_left_op(input logic [3:0] op);
    return (op == OpSll) || (op == OpRol);
  endfunction

  function automatic logic is_rotate_op(input logic [3:0] op);
    return (op == OpRor) || (op == OpRol);
  endfunction

endpackage

// File: rtl/alu_mc_shift.sv
// Combinational shift/rotate/reverse unit; left operations reuse the right shifter by
// reversing the operand before and the result after.
module alu_mc_shift #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [SHW-1:0]   sh,
  input  logic             left,
  input  logic             rotate,
  output logic [WIDTH-1:0] shifted,
  output logic [WIDTH-1:0] reversed
);

  function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < int'(WIDTH); i++) begin
      r[WIDTH-1-i] = x[i];
    end
    return r;
  endfunction

  logic [WIDTH-1:0]   src;
  logic [2*WIDTH-1:0] dbl;
  logic [WIDTH-1:0]   rsh;

  always_comb begin
    src = left ? bit_rev(a) : a;
    // Rotation falls out of shifting a doubled copy of the operand.
    dbl = {src, src} >> sh;
    rsh = rotate ? dbl[WIDTH-1:0] : (src >> sh);
    shifted  = left ? bit_rev(rsh) : rsh;
    reversed = bit_rev(a);
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle handshaked ALU: single-cycle logic/arith/shift ops plus an iterative
// shift-add unsigned multiplier; result and carry are registered and held in DONE.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             busy
);

  if (WIDTH < 16) begin : gen_width_check
    $error("alu_mc: WIDTH must be >= 16");
  end

  alu_state_e state_q, state_d;

  logic [2*WIDTH-1:0] prod_q, prod_next;
  logic [WIDTH-1:0]   mcand_q;
  logic [SHW-1:0]     cnt_q;
  logic               hi_q;
  logic [WIDTH-1:0]   result_q;
  logic               carry_q;

  logic               accept;
  logic               cnt_last;
  logic [SHW-1:0]     sh;
  logic [WIDTH-1:0]   shifted, reversed;
  logic [WIDTH:0]     add_sum, sub_sum, add_hi;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_carry;

  assign accept   = in_valid && in_ready;
  assign cnt_last = (cnt_q == SHW'(WIDTH - 1));
  assign sh       = SHW'(32'(b[SHW-1:0]) % WIDTH);

  alu_mc_shift #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_shift (
    .a        (a),
    .sh       (sh),
    .left     (is_left_op(op)),
    .rotate   (is_rotate_op(op)),
    .shifted  (shifted),
    .reversed (reversed)
  );

  // Subtraction is B - A as ~A + B + 1; carry set means no borrow.
  assign add_sum = {1'b0, a} + {1'b0, b};
  assign sub_sum = {1'b0, ~a} + {1'b0, b} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    alu_res   = a;
    alu_carry = 1'b0;
    unique case (op)
      OpXor:  alu_res = a ^ b;
      OpSlbi: alu_res = {a[WIDTH-9:0], b[7:0]};
      OpAndn: alu_res = a & ~b;
      OpAdd: begin
        alu_res   = add_sum[WIDTH-1:0];
        alu_carry = add_sum[WIDTH];
      end
      OpSub: begin
        alu_res   = sub_sum[WIDTH-1:0];
        alu_carry = sub_sum[WIDTH];
      end
      OpBtr:                      alu_res = reversed;
      OpSrl, OpSll, OpRor, OpRol: alu_res = shifted;
      default:                    alu_res = a;
    endcase
  end

  // One shift-add step: conditional add into the upper half, then shift right with carry.
  always_comb begin
    add_hi    = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {add_hi, prod_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (accept) state_d = is_mul_op(op) ? StMulIter : StDone;
      StMulIter: if (cnt_last) state_d = StDone;
      StDone:    if (out_ready) state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
    busy      = (state_q == StMulIter);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q   <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      hi_q     <= 1'b0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else if (accept) begin
      if (is_mul_op(op)) begin
        prod_q  <= {{WIDTH{1'b0}}, b};
        mcand_q <= a;
        cnt_q   <= '0;
        hi_q    <= (op == OpMulhu);
      end else begin
        result_q <= alu_res;
        carry_q  <= alu_carry;
      end
    end else if (state_q == StMulIter) begin
      prod_q <= prod_next;
      cnt_q  <= cnt_q + SHW'(1);
      if (cnt_last) begin
        result_q <= hi_q ? prod_next[2*WIDTH-1:WIDTH] : prod_next[WIDTH-1:0];
        carry_q  <= hi_q ? 1'b0 : |prod_next[2*WIDTH-1:WIDTH];
      end
    end
  end

  assign result = result_q;
  assign carry  = carry_q;

endmodule

// File: tb/tb_alu_mc.sv
// Randomised and directed bench for alu_mc (WIDTH=16) against an arithmetic reference model.
module tb_alu_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a, b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        carry;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  alu_mc #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Returns {carry, result} from plain integer arithmetic.
  function automatic logic [16:0] model(input logic [3:0] o, input logic [15:0] x,
                                        input logic [15:0] y);
    int unsigned ua, ub, sh, p;
    logic [15:0] r;
    logic        c;
    ua = x;
    ub = y;
    sh = y[3:0];
    p  = ua * ub;
    r  = x;
    c  = 1'b0;
    case (o)
      4'd1: r = x ^ y;
      4'd2: r = 16'(((ua & 32'hFF) << 8) | (ub & 32'hFF));
      4'd3: r = x & ~y;
      4'd4: begin r = 16'(ua + ub); c = (ua + ub) > 32'hFFFF; end
      4'd5: begin r = 16'(ub - ua); c = (ub >= ua); end
      4'd6: for (int i = 0; i < 16; i++) r[15-i] = x[i];
      4'd7: r = 16'(ua >> sh);
      4'd8: r = 16'(ua << sh);
      4'd9: r = 16'((ua >> sh) | (ua << (16 - sh)));
      4'd10: r = 16'((ua << sh) | (ua >> (16 - sh)));
      4'd11: begin r = 16'(p); c = (p >> 16) != 0; end
      4'd12: r = 16'(p >> 16);
      default: r = x;
    endcase
    return {c, r};
  endfunction

  // Issues one op from IDLE, checks latency, busy span, result and carry; hold>0 applies
  // that many cycles of backpressure once the result is valid.
  task automatic run_op(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                        input int hold, input string tag);
    logic [16:0] exp_v;
    int          lat, busy_n;
    bit          mul;
    exp_v = model(o, x, y);
    mul   = (o == 4'd11) || (o == 4'd12);
    check({tag, "/in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    op        = o;
    a         = x;
    b         = y;
    out_ready = (hold == 0);
    lat       = 0;
    busy_n    = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      // Garbage on the inputs while not ready must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      op       = 4'($urandom);
      a        = 16'($urandom);
      b        = 16'($urandom);
      if (busy && !in_ready) busy_n++;
    end while (!out_valid && lat < 40);
    in_valid = 1'b0;
    check({tag, "/latency"}, lat, mul ? 17 : 1);
    check({tag, "/busy_cycles"}, busy_n, mul ? 16 : 0);
    check({tag, "/result"}, result, exp_v[15:0]);
    check({tag, "/carry"}, carry, exp_v[16]);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "/hold_result"}, result, exp_v[15:0]);
      check({tag, "/hold_valid"}, out_valid, 1);
      check({tag, "/hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/released"}, out_valid, 0);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [15:0] ra, rb;
    int unsigned sel;

    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  ro;
    logic [15:0] ra, rb;
    int unsigned sel;

    rst_n     = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      op       = 4'($urandom);
      a        = 16'($urandom);
      b        = 16'($urandom);
      @(posedge clk); #1;
      check("reset/out_valid", out_valid, 0);
      check("reset/in_ready", in_ready, 1);
      check("reset/result", result, 16'h0000);
      check("reset/carry", carry, 0);
      check("reset/busy", busy, 0);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("idle/out_valid", out_valid, 0);
    end

    run_op(4'd4,  16'hFFFF, 16'h0001, 0, "add_wrap");
    check("add_wrap/exact", {carry, result}, 17'h10000);
    run_op(4'd5,  16'h0003, 16'h000A, 0, "sub_pos");
    run_op(4'd5,  16'h000A, 16'h0003, 0, "sub_neg");
    check("sub_neg/exact", {carry, result}, 17'h0FFF9);
    run_op(4'd10, 16'h8001, 16'h0004, 0, "rol");
    check("rol/exact", result, 16'h0018);
    run_op(4'd8,  16'h8001, 16'h0004, 0, "sll");
    run_op(4'd9,  16'h0001, 16'h0001, 0, "ror");
    run_op(4'd7,  16'h8000, 16'h000F, 0, "srl");
    run_op(4'd6,  16'h0001, 16'h0000, 0, "btr");
    run_op(4'd2,  16'h12AB, 16'h00CD, 0, "slbi");
    check("slbi/exact", result, 16'hABCD);
    run_op(4'd9,  16'h1234, 16'h0000, 0, "ror_sh0");
    run_op(4'd11, 16'h0123, 16'h0010, 0, "mul");
    check("mul/exact", {carry, result}, 17'h01230);
    run_op(4'd12, 16'hFFFF, 16'hFFFF, 0, "mulhu_max");
    check("mulhu_max/exact", result, 16'hFFFE);
    run_op(4'd11, 16'hFFFF, 16'hFFFF, 0, "mul_max");
    check("mul_max/exact", {carry, result}, 17'h10001);
    run_op(4'd11, 16'h0000, 16'hFFFF, 0, "mul_zero");
    run_op(4'd15, 16'hBEEF, 16'h1234, 0, "op_pass_alias");
    run_op(4'd1,  16'h00FF, 16'h0F0F, 5, "xor_bp");
    check("xor_bp/exact", result, 16'h0FF0);
    run_op(4'd3,  16'hFFFF, 16'h00F0, 0, "after_bp");

    for (int n = 0; n < 60; n++) begin
      ro  = 4'($urandom);
      sel = $urandom_range(0, 5);
      ra  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      sel = $urandom_range(0, 5);
      rb  = (sel == 0) ? 16'h0000 : (sel == 1) ? 16'hFFFF : 16'($urandom);
      run_op(ro, ra, rb, $urandom_range(0, 3) == 0 ? 2 : 0, $sformatf("rand%0d_op%0d", n, ro));
    end

    // Abort a multiply partway through.
    in_valid  = 1'b1;
    op        = 4'd11;
    a         = 16'h7777;
    b         = 16'h9999;
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("midrst/busy_before", busy, 1);
    rst_n = 1'b0;
    #1;
    check("midrst/out_valid", out_valid, 0);
    check("midrst/busy", busy, 0);
    check("midrst/in_ready", in_ready, 1);
    check("midrst/result", result, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst/no_result", out_valid, 0);
    run_op(4'd4, 16'h0002, 16'h0003, 0, "midrst_add");
    check("midrst_add/exact", result, 16'h0005);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle, handshaked ALU; successor to the single-cycle 16-bit datapath ALU.
- Generalised to WIDTH bits with a registered result.
- Adds iterative unsigned multiply: MUL returns the low half, MULHU the high half.
- Sits between decode/operand-read and writeback; stalls the front end through in_ready while a multiply iterates.

Parameters:
- WIDTH, 16: operand/result width; must be >= 16 (SLBI needs 8 upper bits); elaboration error otherwise.
- SHW, $clog2(WIDTH): shift-amount width, taken from B[SHW-1:0].

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  block can accept; high only in IDLE.
- op  in  4  operation code (shared header).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- out_valid  out  1  result/carry valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- carry  out  1  registered carry/overflow flag.
- busy  out  1  high in MUL_ITER.

Behaviour:
- Reset (async, rst_n low): state=IDLE; in_ready=1; out_valid=0; busy=0; result=0; carry=0; multiply accumulator, multiplicand and counter cleared.
- Reset mid-operation aborts immediately; no result is produced.
- States:
  - IDLE: accept when in_valid&&in_ready. Single-cycle op -> DONE. MUL/MULHU -> MUL_ITER.
  - MUL_ITER: shift-add, one multiplier bit per cycle. Counter runs 0..WIDTH-1; at WIDTH-1 -> DONE.
  - DONE: out_valid=1; result/carry held stable. out_valid&&out_ready -> IDLE.
- No back-to-back issue: in_ready low in DONE.
- Latency: 1 cycle for single-cycle ops (accept at edge N, out_valid after edge N+1). WIDTH+1 cycles for multiply.
- Operands and op are captured at accept; later input changes are ignored.
- Ops (result / carry):
  - PASS (0000): A / 0.
  - XOR (0001): A^B / 0.
  - SLBI (0010): {A[WIDTH-9:0],B[7:0]} / 0.
  - ANDN (0011): A&~B / 0.
  - ADD (0100): A+B / carry-out of bit WIDTH-1.
  - SUB (0101): B-A, computed as ~A+B+1 / carry-out of that sum (1 = no borrow).
  - BTR (0110): bit-reverse A / 0.
  - SRL (0111): A>>sh, zero fill / 0.
  - SLL (1000): A<<sh / 0.
  - ROR (1001): rotate A right by sh / 0.
  - ROL (1010): rotate A left by sh / 0.
  - MUL (1011): low WIDTH bits of A*B (unsigned) / 1 if high half nonzero.
  - MULHU (1100): high WIDTH bits of A*B / 0.
  - 1101-1111: behave as PASS.
- Shift amount sh = B[SHW-1:0] modulo WIDTH; sh=0 returns A unchanged for all shift/rotate ops.
- Multiply datapath: 2*WIDTH-bit product register. Each cycle, if the current multiplier LSB is 1, add the multiplicand into the upper half with carry, then shift the product right by 1.
- Boundaries:
  - Operands of 0 or all-ones must produce exact results.
  - in_valid asserted while not ready has no effect.
  - out_ready held high completes the handshake in DONE's first cycle.

Decomposition:
- Shared header (existing ops header, extended): 4-bit op codes above, plus state encodings IDLE=2'd0, MUL_ITER=2'd1, DONE=2'd2.
- Sub-module alu_mc_shift: combinational WIDTH-parametrised shift/rotate/reverse. Uses pre/post bit-reversal to derive left shifts from a right shifter.
- Adder and multiplier iteration stay in the top level.

Test Plan (WIDTH=16):
- Reset: hold rst_n=0 with random inputs -> out_valid=0, in_ready=1, result=0x0000; release, idle 3 cycles -> no out_valid.
- ADD and SUB:
  - ADD a=0xFFFF b=0x0001 -> result=0x0000, carry=1, out_valid exactly one cycle after accept.
  - SUB a=0x0003 b=0x000A -> 0x0007, carry=1.
  - SUB a=0x000A b=0x0003 -> 0xFFF9, carry=0.
- Shifts:
  - ROL a=0x8001 b=4 -> 0x0018.
  - SLL a=0x8001 b=4 -> 0x0010.
  - ROR a=0x0001 b=1 -> 0x8000.
  - SRL a=0x8000 b=15 -> 0x0001.
  - BTR a=0x0001 -> 0x8000.
  - SLBI a=0x12AB b=0x00CD -> 0xABCD.
- Multiply:
  - MUL a=0x0123 b=0x0010 -> 0x1230, carry=0; in_ready low and busy high for 16 cycles; out_valid 17 cycles after accept.
  - MULHU a=0xFFFF b=0xFFFF -> 0xFFFE.
  - MUL same operands -> 0x0001, carry=1.
- Backpressure: after XOR a=0x00FF b=0x0F0F, hold out_ready=0 for 5 cycles -> result 0x0FF0 stable, out_valid high, in_ready low; raise out_ready -> IDLE next cycle; new op then accepted.
- Reset mid-multiply: assert rst_n=0 at iteration 7 of a MUL -> out_valid=0 and busy=0 immediately; after release, ADD 2+3 -> 0x0005 with normal 1-cycle latency.
